clock_set_ctrl: RTL
===================

# clock_set_ctrl

Timekeeping and set-control core of the digital clock. Consumes the six debounced set-button levels (minute, hour, day, month, year, century), converts them to single-step or auto-repeat increment pulses, and maintains the running time/date registers (sec, min, hrs, day, mon, year, cen) from an internal 1 Hz prescaler with full calendar carry and leap-year handling. Outputs feed the display/BCD stage.

## Interface
- CLK_HZ, 50_000_000: clock cycles per second tick
- REPEAT_DELAY, 25_000_000: cycles a button must be held after its first pulse before auto-repeat starts
- REPEAT_RATE, 6_250_000: cycles between auto-repeat pulses
- clk_50MHz  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- w_min_b, w_hrs_b, w_day_b, w_mon_b, w_year_b, w_cen_b  in  1 each  debounced button levels, active-high
- tick_1hz  out  1  one-cycle pulse on each seconds increment
- sec  out  6  0..59
- min  out  6  0..59
- hrs  out  5  0..23
- day  out  5  1..days_in_month
- mon  out  4  1..12
- year  out  7  0..99
- cen  out  7  0..99

## Operation
- Reset (rst high at an edge): sec=0, min=0, hrs=0, day=1, mon=1, year=0, cen=20, tick_1hz=0, prescaler=0, all button pulse/repeat state cleared; reset overrides everything in that cycle.
- Prescaler counts 0..CLK_HZ-1; at count CLK_HZ-1 it wraps to 0 and a tick occurs.
- Tick: sec+1; 59 wraps to 0 with carry to min; min 59 to hrs; hrs 23 to day; day==days_in_month to day=1 and mon+1; mon 12 to mon=1 and year+1; year 99 to year=0 and cen+1; cen 99 wraps to 0.
- days_in_month: 31 for months 1,3,5,7,8,10,12; 30 for 4,6,9,11; Feb 29 if leap else 28. Leap: year%4==0 and (year!=0 or cen%4==0), so 2000 is leap, 1900 is not.
- Per-button pulse generator, 6 instances, states IDLE, HOLD, REPEAT:
  - IDLE: level rises (prev=0, now=1) -> one pulse, go to HOLD, counter=0.
  - HOLD: counter+1 each cycle; level low -> IDLE; counter reaches REPEAT_DELAY-1 -> pulse, REPEAT, counter=0.
  - REPEAT: level low -> IDLE; counter reaches REPEAT_RATE-1 -> pulse, counter=0.
- Set pulses increment only their own field, no carry: min 59->0, hrs 23->0, day dim->1, mon 12->1, year 99->0, cen 99->0.
- A min set pulse also clears sec and the prescaler.
- After any mon/year/cen change by set or carry, day is clamped to the new days_in_month in the same update. Example: Jan 31 +mon gives Feb 29 or Feb 28.
- Simultaneous set pulses: all addressed fields update in the same cycle; the day clamp uses the updated mon/year/cen.
- Tick coincident with any set pulse: set pulses apply, and the tick is held in a pending flag and applied on the next cycle with no set pulse. tick_1hz asserts when the tick is applied.
- A min set pulse discards any pending tick.

## Timing
- Button level first sampled high at edge N: pulse registered at N, field updated at edge N+1 (visible after N+1).
- Auto-repeat: second pulse REPEAT_DELAY cycles after the first, then every REPEAT_RATE cycles while held.
- First tick CLK_HZ edges after reset deasserts; tick_1hz is high for exactly the cycle in which sec (and any carries) show the new value.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Package clock_set_pkg: reset constants (RST_CEN=20, RST_DAY=1, RST_MON=1), field maximums, days_in_month(mon, year, cen) and is_leap(year, cen) functions, and the pulse-FSM state enum.
- Sub-module btn_pulse (params REPEAT_DELAY, REPEAT_RATE; ports clk_50MHz, rst, level in, pulse out), instantiated six times. Counter width is $clog2 of the larger parameter.
- Top level holds the prescaler, pending-tick flag, and field update logic.

## Test plan
Benches use CLK_HZ=10, REPEAT_DELAY=20, REPEAT_RATE=5.
- Reset then run 600 cycles -> outputs 00:01:00 on 20/00-01-01; tick_1hz pulses exactly 60 times, 10 cycles apart.
- Preload 23:59:59 on 99/12-31 (cen=20, via set pulses) and tick -> 00:00:00 on 21/00-01-01 in one update.
- Set 2000-02-28 23:59:59 and tick -> Feb 29. Repeat with cen=19, year=00 -> Mar 1.
- Date Jan 31: one mon pulse -> Feb 29 (year 0, cen 20). Then year pulse -> day clamps to 28.
- Hold w_min_b 31 cycles from min=0 -> pulses at cycle offsets 0, 20, 25, 30; min=4 and sec=0. Release mid-HOLD -> no extra pulse.
- Day pulse on the same edge as a tick, with rst asserted mid-REPEAT -> day updates first and sec increments one cycle later; rst returns all outputs to reset values and no pulse follows its release while the button is still held.

Source files
------------

// File: rtl/clock_set_pkg.sv
// Shared constants, calendar helpers and pulse-FSM state type for the clock set/timekeeping core.
package clock_set_pkg;

    localparam int unsigned SEC_W  = 6;
    localparam int unsigned MIN_W  = 6;
    localparam int unsigned HRS_W  = 5;
    localparam int unsigned DAY_W  = 5;
    localparam int unsigned MON_W  = 4;
    localparam int unsigned YEAR_W = 7;
    localparam int unsigned CEN_W  = 7;

    localparam int unsigned NUM_BTN  = 6;
    localparam int unsigned SET_MIN  = 0;
    localparam int unsigned SET_HRS  = 1;
    localparam int unsigned SET_DAY  = 2;
    localparam int unsigned SET_MON  = 3;
    localparam int unsigned SET_YEAR = 4;
    localparam int unsigned SET_CEN  = 5;

    localparam logic [CEN_W-1:0] RST_CEN = 7'd20;
    localparam logic [DAY_W-1:0] RST_DAY = 5'd1;
    localparam logic [MON_W-1:0] RST_MON = 4'd1;

    localparam logic [SEC_W-1:0]  MAX_SEC  = 6'd59;
    localparam logic [MIN_W-1:0]  MAX_MIN  = 6'd59;
    localparam logic [HRS_W-1:0]  MAX_HRS  = 5'd23;
    localparam logic [MON_W-1:0]  MAX_MON  = 4'd12;
    localparam logic [YEAR_W-1:0] MAX_YEAR = 7'd99;
    localparam logic [CEN_W-1:0]  MAX_CEN  = 7'd99;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_REPEAT
    } pulse_state_e;

    // Year 00 is leap only when the century is divisible by 4 (2000 yes, 1900 no).
    function automatic logic is_leap(input logic [YEAR_W-1:0] year, input logic [CEN_W-1:0] cen);
        return (year[1:0] == 2'd0) && ((year != 7'd0) || (cen[1:0] == 2'd0));
    endfunction

    function automatic logic [DAY_W-1:0] days_in_month(input logic [MON_W-1:0] mon,
                                                       input logic [YEAR_W-1:0] year,
                                                       input logic [CEN_W-1:0] cen);
        logic [DAY_W-1:0] dim;
        case (mon)
            4'd4, 4'd6, 4'd9, 4'd11: dim = 5'd30;
            4'd2:                    dim = is_leap(year, cen) ? 5'd29 : 5'd28;
            default:                 dim = 5'd31;
        endcase
        return dim;
    endfunction

endpackage

// File: rtl/clock_set_ctrl_btn_pulse.sv
// Converts a debounced button level into a single press pulse followed by auto-repeat pulses while held.
module btn_pulse
    import clock_set_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY = 25_000_000,
    parameter int unsigned REPEAT_RATE  = 6_250_000
) (
    input  logic clk_50MHz,
    input  logic rst,
    input  logic level,
    output logic pulse
);

    localparam int unsigned CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    pulse_state_e     state;
    logic             prev;
    logic [CNT_W-1:0] cnt;

    // prev resets high so a button still held through reset needs a release before it fires again.
    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            state <= ST_IDLE;
            prev  <= 1'b1;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            prev  <= level;
            pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (level && !prev) begin
                        pulse <= 1'b1;
                        state <= ST_HOLD;
                        cnt   <= '0;
                    end
                end
                ST_HOLD: begin
                    if (!level) begin
                        state <= ST_IDLE;
                    end else if (cnt == CNT_W'(REPEAT_DELAY - 1)) begin
                        pulse <= 1'b1;
                        state <= ST_REPEAT;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_REPEAT: begin
                    if (!level) begin
                        state <= ST_IDLE;
                    end else if (cnt == CNT_W'(REPEAT_RATE - 1)) begin
                        pulse <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// Running time/date registers with 1 Hz prescaler, calendar carry, and button-driven field setting.
module clock_set_ctrl
    import clock_set_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 50_000_000,
    parameter int unsigned REPEAT_DELAY = 25_000_000,
    parameter int unsigned REPEAT_RATE  = 6_250_000
) (
    input  logic              clk_50MHz,
    input  logic              rst,
    input  logic              w_min_b,
    input  logic              w_hrs_b,
    input  logic              w_day_b,
    input  logic              w_mon_b,
    input  logic              w_year_b,
    input  logic              w_cen_b,
    output logic              tick_1hz,
    output logic [SEC_W-1:0]  sec,
    output logic [MIN_W-1:0]  min,
    output logic [HRS_W-1:0]  hrs,
    output logic [DAY_W-1:0]  day,
    output logic [MON_W-1:0]  mon,
    output logic [YEAR_W-1:0] year,
    output logic [CEN_W-1:0]  cen
);

    localparam int unsigned PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    logic [NUM_BTN-1:0] lvl;
    logic [NUM_BTN-1:0] set_p;

    assign lvl = {w_cen_b, w_year_b, w_mon_b, w_day_b, w_hrs_b, w_min_b};

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_pulse #(
            .REPEAT_DELAY(REPEAT_DELAY),
            .REPEAT_RATE (REPEAT_RATE)
        ) u_btn (
            .clk_50MHz(clk_50MHz),
            .rst      (rst),
            .level    (lvl[i]),
            .pulse    (set_p[i])
        );
    end

    logic [PRE_W-1:0]  presc, presc_n;
    logic              pending, pending_n, tick_n, tick_raw;
    logic [SEC_W-1:0]  sec_n;
    logic [MIN_W-1:0]  min_n;
    logic [HRS_W-1:0]  hrs_n;
    logic [DAY_W-1:0]  day_n, dim_cur, dim_new;
    logic [MON_W-1:0]  mon_n;
    logic [YEAR_W-1:0] year_n;
    logic [CEN_W-1:0]  cen_n;

    // Set pulses take priority; a tick that collides with them is deferred to the next quiet cycle.
    always_comb begin
        tick_raw  = (presc == PRE_W'(CLK_HZ - 1));
        presc_n   = tick_raw ? '0 : presc + PRE_W'(1);
        pending_n = pending;
        tick_n    = 1'b0;
        sec_n     = sec;
        min_n     = min;
        hrs_n     = hrs;
        day_n     = day;
        mon_n     = mon;
        year_n    = year;
        cen_n     = cen;
        dim_cur   = days_in_month(mon, year, cen);
        dim_new   = dim_cur;

        if (set_p != '0) begin
            if (set_p[SET_MIN]) begin
                min_n     = (min == MAX_MIN) ? '0 : min + 6'd1;
                sec_n     = '0;
                presc_n   = '0;
                pending_n = 1'b0;
            end else begin
                pending_n = pending | tick_raw;
            end
            if (set_p[SET_HRS])  hrs_n  = (hrs == MAX_HRS)   ? '0   : hrs + 5'd1;
            if (set_p[SET_MON])  mon_n  = (mon == MAX_MON)   ? 4'd1 : mon + 4'd1;
            if (set_p[SET_YEAR]) year_n = (year == MAX_YEAR) ? '0   : year + 7'd1;
            if (set_p[SET_CEN])  cen_n  = (cen == MAX_CEN)   ? '0   : cen + 7'd1;
            dim_new = days_in_month(mon_n, year_n, cen_n);
            if (set_p[SET_DAY])  day_n  = (day >= dim_new) ? 5'd1 : day + 5'd1;
        end else if (tick_raw || pending) begin
            tick_n    = 1'b1;
            pending_n = 1'b0;
            sec_n     = sec + 6'd1;
            if (sec == MAX_SEC) begin
                sec_n = '0;
                min_n = min + 6'd1;
                if (min == MAX_MIN) begin
                    min_n = '0;
                    hrs_n = hrs + 5'd1;
                    if (hrs == MAX_HRS) begin
                        hrs_n = '0;
                        day_n = day + 5'd1;
                        if (day >= dim_cur) begin
                            day_n = 5'd1;
                            mon_n = mon + 4'd1;
                            if (mon == MAX_MON) begin
                                mon_n  = 4'd1;
                                year_n = year + 7'd1;
                                if (year == MAX_YEAR) begin
                                    year_n = '0;
                                    cen_n  = (cen == MAX_CEN) ? '0 : cen + 7'd1;
                                end
                            end
                        end
                    end
                end
            end
            dim_new = days_in_month(mon_n, year_n, cen_n);
        end

        if (day_n > dim_new) day_n = dim_new;
    end

    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            presc    <= '0;
            pending  <= 1'b0;
            tick_1hz <= 1'b0;
            sec      <= '0;
            min      <= '0;
            hrs      <= '0;
            day      <= RST_DAY;
            mon      <= RST_MON;
            year     <= '0;
            cen      <= RST_CEN;
        end else begin
            presc    <= presc_n;
            pending  <= pending_n;
            tick_1hz <= tick_n;
            sec      <= sec_n;
            min      <= min_n;
            hrs      <= hrs_n;
            day      <= day_n;
            mon      <= mon_n;
            year     <= year_n;
            cen      <= cen_n;
        end
    end

endmodule
